// File: rtl/instruction_fetch_unit.sv
// PC generation and IF/ID stage feeding a combinational instruction memory.
// Define IFU_FETCH_COUNT_EN to add the fetch_count output.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 36
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic        misalign_err
`ifdef IFU_FETCH_COUNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_t;

  localparam logic [32:0] LIMIT = 33'(IMEM_BYTES);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  if_id_t      ifid_q, ifid_d;
  logic        mis_q, mis_d;

  logic [32:0] pc_end;
  logic        fits;
  logic        redir;
  logic        fetch_en;
  logic        drain;

  // 33-bit sum so a PC near the top of the space cannot wrap into range
  assign pc_end   = {1'b0, pc_q} + 33'd4;
  assign fits     = (pc_end <= LIMIT);
  assign redir    = redirect_valid && (state_q != IDLE);
  assign drain    = ifid_q.valid && id_ready;
  assign fetch_en = (state_q == RUN) && fits && !redirect_valid
                 && (!ifid_q.valid || id_ready);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    mis_d   = mis_q;
    unique case (1'b1)
      redir: begin
        pc_d         = {redirect_pc[31:2], 2'b00};
        ifid_d.valid = 1'b0;
        state_d      = RUN;
        mis_d        = mis_q | (redirect_pc[1:0] != 2'b00);
      end
      (state_q == IDLE): begin
        state_d = RUN;
      end
      fetch_en: begin
        ifid_d.valid = 1'b1;
        ifid_d.instr = imem_instr;
        ifid_d.pc    = pc_q;
        pc_d         = pc_q + 32'd4;
      end
      default: begin
        if (drain) ifid_d.valid = 1'b0;
        if ((state_q == RUN) && !fits) state_d = HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ifid_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      mis_q   <= mis_d;
    end
  end

`ifdef IFU_FETCH_COUNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (fetch_en) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign fetch_count = cnt_q;
`endif

  assign imem_pc      = pc_q;
  assign if_valid     = ifid_q.valid;
  assign if_instr     = ifid_q.instr;
  assign if_pc        = ifid_q.pc;
  assign halted       = (state_q == HALT);
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed plan plus random
// stimulus against a fetch-queue reference model.
module tb_instruction_fetch_unit;

  localparam int IMEM = 36;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic        misalign_err;
`ifdef IFU_FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC  (32'h0),
    .IMEM_BYTES(IMEM)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_pc       (imem_pc),
    .imem_instr    (imem_instr),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .id_ready      (id_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halted        (halted),
    .misalign_err  (misalign_err)
`ifdef IFU_FETCH_COUNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  logic [31:0] mem [9];

  initial begin
    mem[0] = 32'h0094_0333;
    mem[1] = 32'h4139_03b3;
    mem[2] = 32'h035a_02b3;
    mem[3] = 32'h037b_4e33;
    mem[4] = 32'h0050_0093;
    mem[5] = 32'h00a0_0113;
    mem[6] = 32'h0020_81b3;
    mem[7] = 32'h4011_0233;
    mem[8] = 32'h0000_006f;
  end

  always_comb begin
    imem_instr = 32'hDEAD_BEEF;
    if (imem_pc < 32'(IMEM)) imem_instr = mem[int'(imem_pc >> 2)];
  end

  int cmp = 0;
  int bad = 0;

  // Reference: a word pointer walking memory, one output slot,
  // and "halted" meaning the pointer has run off the end.
  longint      m_pc;
  bit          m_idle, m_v, m_h, m_m;
  logic [31:0] m_instr, m_ipc, m_cnt;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_idle = 1; m_v = 0; m_h = 0; m_m = 0;
    m_instr = 0; m_ipc = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit rst, input bit rdy,
                            input bit rv, input logic [31:0] rp);
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_idle) begin
      m_idle = 0;
      return;
    end
    if (rv) begin
      m_pc = longint'(rp) - longint'(rp % 4);
      m_v  = 0;
      m_h  = 0;
      if (rp % 4 != 0) m_m = 1;
      return;
    end
    if (m_pc + 4 > IMEM) begin
      m_h = 1;
      if (m_v && rdy) m_v = 0;
      return;
    end
    if (!m_v || rdy) begin
      m_instr = mem[int'(m_pc / 4)];
      m_ipc   = 32'(m_pc);
      m_v     = 1;
      m_pc    = m_pc + 4;
      m_cnt   = m_cnt + 1;
    end
  endtask

  task automatic compare_all();
    chk("imem_pc", imem_pc, 32'(m_pc));
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_v});
    chk("if_instr", if_instr, m_instr);
    chk("if_pc", if_pc, m_ipc);
    chk("halted", {31'd0, halted}, {31'd0, m_h});
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_m});
`ifdef IFU_FETCH_COUNT_EN
    chk("fetch_count", fetch_count, m_cnt);
`endif
  endtask

  task automatic tick(input bit rst, input bit rdy,
                      input bit rv, input logic [31:0] rp);
    reset          = rst;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    model_step(rst, rdy, rv, rp);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    reset = 0; id_ready = 1; redirect_valid = 0; redirect_pc = 0;
    model_reset();
    @(negedge clk);
    compare_all();
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    tick(0, 1, 0, 0);

    // release, IDLE cycle, then first fetch
    tick(1, 1, 0, 0);
    chk("idle_no_fetch", {31'd0, if_valid}, 32'd0);
    tick(1, 1, 0, 0);
    chk("first_instr", if_instr, 32'h0094_0333);
    chk("first_pc", if_pc, 32'd0);
    tick(1, 1, 0, 0);
    chk("second_instr", if_instr, 32'h4139_03b3);

    // stall three cycles
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0);
      chk("stall_instr", if_instr, 32'h4139_03b3);
      chk("stall_pc", if_pc, 32'd4);
      chk("stall_imem_pc", imem_pc, 32'd8);
    end
    tick(1, 1, 0, 0);
    chk("after_stall", if_instr, 32'h035a_02b3);
    tick(1, 1, 0, 0);
    chk("fourth_instr", if_instr, 32'h037b_4e33);
    chk("fourth_pc", if_pc, 32'd12);
`ifdef IFU_FETCH_COUNT_EN
    chk("count_4", fetch_count, 32'd4);
`endif

    // run to end of memory
    for (int i = 0; i < 5; i++) tick(1, 1, 0, 0);
    chk("last_pc", if_pc, 32'd32);
    chk("end_imem_pc", imem_pc, 32'd36);
    chk("not_yet_halted", {31'd0, halted}, 32'd0);
    tick(1, 0, 0, 0);
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halt_hold_valid", {31'd0, if_valid}, 32'd1);
    tick(1, 1, 0, 0);
    chk("halt_drain", {31'd0, if_valid}, 32'd0);
    chk("halt_pc_held", imem_pc, 32'd36);

    // redirect out of HALT
    tick(1, 1, 1, 32'd4);
    chk("unhalt", {31'd0, halted}, 32'd0);
    chk("redir_flush", {31'd0, if_valid}, 32'd0);
    tick(1, 1, 0, 0);
    chk("redir_instr", if_instr, 32'h4139_03b3);
    chk("redir_pc", if_pc, 32'd4);

    // misaligned redirect
    tick(1, 1, 1, 32'd0);
    tick(1, 0, 0, 0);
    chk("pc0_valid", if_pc, 32'd0);
    tick(1, 1, 1, 32'h0000_000E);
    chk("mis_flush", {31'd0, if_valid}, 32'd0);
    chk("mis_pc", imem_pc, 32'd12);
    chk("mis_flag", {31'd0, misalign_err}, 32'd1);
    tick(1, 1, 0, 0);
    chk("mis_instr", if_instr, 32'h037b_4e33);
    chk("mis_sticky", {31'd0, misalign_err}, 32'd1);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #2 reset = 0;
    #1;
    chk("async_valid", {31'd0, if_valid}, 32'd0);
    chk("async_pc", imem_pc, 32'd0);
    model_reset();
    @(negedge clk);
    compare_all();
`ifdef IFU_FETCH_COUNT_EN
    chk("count_reset", fetch_count, 32'd0);
`endif
    tick(0, 1, 0, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      bit          rst, rdy, rv;
      logic [31:0] rp;
      rst = ($urandom_range(0, 199) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       rp = 32'($urandom_range(0, 44));
        1:       rp = 32'($urandom_range(0, 8)) << 2;
        2:       rp = $urandom;
        default: rp = 32'hFFFF_FFFC;
      endcase
      tick(rst, rdy, rv, rp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
PC-generation and IF/ID pipeline stage that sits directly upstream of Instruction_Memory.
- Drives the byte address into the instruction memory's combinational read port.
- Captures the returned 32-bit instruction and its PC into an IF/ID register.
- Hands the register to decode with a valid/ready handshake.
- Supports branch/jump redirect with flush, and halts cleanly at the end of instruction memory.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded while reset is low; must be word-aligned
IMEM_BYTES, 36, instruction memory size in bytes; must be a multiple of 4

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset; low = in reset (same net that initializes Instruction_Memory)
imem_pc  output  32  byte address to Instruction_Memory PC input; equals pc_q
imem_instr  input  32  Instruction_Code from Instruction_Memory, same-cycle combinational
if_valid  output  1  IF/ID register holds a valid instruction
if_instr  output  32  IF/ID instruction word
if_pc  output  32  PC of if_instr
id_ready  input  1  decode accepts IF/ID contents this cycle when if_valid=1
redirect_valid  input  1  one-cycle redirect request (taken branch/jump)
redirect_pc  input  32  redirect target
halted  output  1  fetch stopped at end of memory
misalign_err  output  1  sticky; set by any redirect with redirect_pc[1:0] != 0

Behaviour:
Reset (reset=0, asynchronous):
- pc_q=RESET_PC, state=IDLE.
- if_valid=0, if_instr=0, if_pc=0, halted=0, misalign_err=0.

States: IDLE, RUN, HALT.

IDLE:
- Occupies exactly one cycle after reset deasserts, which lets memory initialization settle.
- No fetch; then -> RUN.

RUN:
- fetch_en = (!if_valid || id_ready) && (pc_q + 4 <= IMEM_BYTES) && !redirect_valid.
- On fetch_en: if_instr<=imem_instr, if_pc<=pc_q, if_valid<=1, pc_q<=pc_q+4. Latency is one cycle, PC to if_valid.
- If if_valid && !id_ready: hold pc_q and the IF/ID register unchanged.
- If !fetch_en, if_valid && id_ready: if_valid<=0.
- If pc_q + 4 > IMEM_BYTES and no redirect: -> HALT, halted<=1. The boundary check uses 33-bit arithmetic, so there is no wrap.

HALT:
- No fetch; pc_q held; halted=1.
- The IF/ID register still drains: if_valid<=0 when id_ready.

Redirect (any state except IDLE; highest priority):
- pc_q<={redirect_pc[31:2],2'b00}.
- if_valid<=0 (flush), regardless of id_ready.
- state<=RUN, halted<=0.
- misalign_err<=1 if redirect_pc[1:0]!=0.
- Redirect during IDLE is ignored.

Simultaneous events:
- Redirect plus a would-be fetch: redirect wins; no fetch that cycle.
- Redirect plus id_ready handshake: the instruction counts as consumed by decode; the register is still cleared.

Reset mid-operation returns all state to reset values immediately; any in-flight IF/ID contents are discarded.

imem_instr is sampled only on fetch_en; X on imem_instr at other times must not propagate.

Optional Feature:
Macro IFU_FETCH_COUNT_EN.
- Defined: adds output fetch_count [31:0].
  - Reset to 0.
  - Increments by 1 on every fetch_en cycle; wraps 32'hFFFF_FFFF -> 0.
  - Not cleared by redirect.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Memory holds 0x00940333/0x413903b3/0x035a02b3/0x037b4e33 at 0/4/8/12; reset low 2 cycles then high; id_ready=1 -> if_valid first high 2 cycles after release (IDLE+fetch). if_instr sequence 0x00940333, 0x413903b3, 0x035a02b3, 0x037b4e33 with if_pc 0, 4, 8, 12.
2. id_ready=0 for 3 cycles while if_instr=0x413903b3 -> if_instr/if_pc (4) and imem_pc (8) frozen; on id_ready=1 the next cycle gives 0x035a02b3.
3. Run to end with IMEM_BYTES=36 -> last fetch at if_pc=32; imem_pc reaches 36; halted=1 the next cycle; if_valid drops after id_ready; imem_pc stays 36.
4. In HALT, redirect_valid=1, redirect_pc=4 -> halted=0, if_valid=0, next fetched if_instr=0x413903b3, if_pc=4.
5. While if_valid=1 at if_pc=0, redirect_pc=0x0000000E -> flush; pc_q=12; misalign_err=1 and stays 1; next if_instr=0x037b4e33.
6. Assert reset low mid-run with if_valid=1 -> same-cycle (asynchronous) if_valid=0, imem_pc=RESET_PC. With IFU_FETCH_COUNT_EN: fetch_count=4 after scenario 1, then 0 after reset.
